// File: rtl/tl_scratchpad_responder.sv
// rtl/tl_scratchpad_responder.sv - TileLink-UL scratchpad responder, 64-bit RAM, 2-entry D queue
// Optional request denial (alignment, opcode, corrupt Put) is enabled by TL_SCRATCHPAD_DENY_EN.
module tl_scratchpad_responder #(
    parameter int DEPTH = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [10:0] auto_in_a_bits_source,
    input  logic [11:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [10:0] auto_in_d_bits_source,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_denied
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 1 + 3 + 2 + 11 + 64;

    logic [63:0]   r_mem [DEPTH];
    logic [63:0]   r_rdata;
    logic [1:0]    r_resv;

    logic          r_p_valid;
    logic [2:0]    r_p_opcode;
    logic [1:0]    r_p_size;
    logic [10:0]   r_p_source;
    logic          r_p_denied;
    logic          r_p_has_data;

    logic [EW-1:0] r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic          w_a_ready;
    logic          w_a_fire;
    logic          w_is_put;
    logic          w_known;
    logic          w_misaligned;
    logic          w_denied;
    logic [AW-1:0] w_idx;
    logic [EW-1:0] w_p_entry;
    logic [EW-1:0] w_head;
    logic          w_f_empty;
    logic          w_d_valid;
    logic          w_d_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_a_ready = (r_resv < 2'd2);
    assign w_a_fire  = auto_in_a_valid && w_a_ready;
    assign w_is_put  = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign w_known   = w_is_put || (auto_in_a_bits_opcode == 3'd4);
    assign w_idx     = auto_in_a_bits_address[3 +: AW];

    always_comb begin
        w_misaligned = 1'b0;
        case (auto_in_a_bits_size)
            2'd1:    w_misaligned = auto_in_a_bits_address[0];
            2'd2:    w_misaligned = |auto_in_a_bits_address[1:0];
            2'd3:    w_misaligned = |auto_in_a_bits_address[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

`ifdef TL_SCRATCHPAD_DENY_EN
    assign w_denied = !w_known || w_misaligned || (w_is_put && auto_in_a_bits_corrupt);
`else
    assign w_denied = 1'b0;
`endif

    assign w_unused = ^{auto_in_a_bits_param, auto_in_a_bits_address, auto_in_a_bits_corrupt,
                        w_known, w_misaligned};

    // RAM is deliberately unreset; a Put write lands at the accept edge so a following Get sees it.
    always_ff @(posedge clock) begin
        if (w_a_fire) begin
            if (w_is_put) begin
                if (!w_denied) begin
                    for (int i = 0; i < 8; i++) begin
                        if (auto_in_a_bits_mask[i]) begin
                            r_mem[w_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
                        end
                    end
                end
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p_valid    <= 1'b0;
            r_p_opcode   <= 3'd0;
            r_p_size     <= 2'd0;
            r_p_source   <= 11'd0;
            r_p_denied   <= 1'b0;
            r_p_has_data <= 1'b0;
        end else begin
            r_p_valid <= w_a_fire;
            if (w_a_fire) begin
                r_p_opcode   <= w_is_put ? 3'd0 : 3'd1;
                r_p_size     <= auto_in_a_bits_size;
                r_p_source   <= auto_in_a_bits_source;
                r_p_denied   <= w_denied;
                r_p_has_data <= !w_is_put && !w_denied;
            end
        end
    end

    assign w_p_entry = {r_p_denied, r_p_opcode, r_p_size, r_p_source,
                        (r_p_has_data ? r_rdata : 64'h0)};

    // The stage-R entry is presented directly when the queue is empty, giving one-cycle latency;
    // it is pushed into the queue only if not consumed this cycle.
    assign w_f_empty = (r_count == 2'd0);
    assign w_head    = w_f_empty ? w_p_entry : r_fifo[r_rptr];
    assign w_d_valid = !w_f_empty || r_p_valid;
    assign w_d_fire  = w_d_valid && auto_in_d_ready;
    assign w_pop     = w_d_fire && !w_f_empty;
    assign w_push    = r_p_valid && !(w_f_empty && auto_in_d_ready);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_p_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resv <= 2'd0;
        end else begin
            case ({w_a_fire, w_d_fire})
                2'b10:   r_resv <= r_resv + 2'd1;
                2'b01:   r_resv <= r_resv - 2'd1;
                default: r_resv <= r_resv;
            endcase
        end
    end

    assign auto_in_a_ready = w_a_ready;
    assign auto_in_d_valid = w_d_valid;
    assign {auto_in_d_bits_denied, auto_in_d_bits_opcode, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_data} = w_d_valid ? w_head : {EW{1'b0}};

endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// tb/tb_tl_scratchpad_responder.sv - self-checking bench for tl_scratchpad_responder
module tb_tl_scratchpad_responder;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [10:0] src;
        logic [63:0] data;
        logic        den;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_op = 3'd0;
    logic [2:0]  a_param = 3'd0;
    logic [1:0]  a_size = 2'd3;
    logic [10:0] a_src = 11'd0;
    logic [11:0] a_addr = 12'd0;
    logic [7:0]  a_mask = 8'hFF;
    logic [63:0] a_data = 64'h0;
    logic        a_corrupt = 1'b0;
    logic        d_valid;
    logic        d_rdy = 1'b1;
    logic [2:0]  d_op;
    logic [1:0]  d_size;
    logic [10:0] d_src;
    logic [63:0] d_data;
    logic        d_den;

    int    vectors = 0;
    int    miscompares = 0;
    bit    last_a_fire;
    resp_t q[$];
    logic [63:0] mdl_mem [512];

    tl_scratchpad_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_bits_opcode  (a_op),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_src),
        .auto_in_a_bits_address (a_addr),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_ready        (d_rdy),
        .auto_in_d_bits_opcode  (d_op),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_src),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_denied  (d_den)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted request: returns the response it must produce.
    task automatic model_accept(output resp_t r);
        bit put, known, mis, den;
        int idx;
        put   = (a_op == 3'd0) || (a_op == 3'd1);
        known = put || (a_op == 3'd4);
        mis   = (int'(a_addr) % (1 << a_size)) != 0;
        den   = 1'b0;
`ifdef TL_SCRATCHPAD_DENY_EN
        den   = !known || mis || (put && a_corrupt);
`endif
        idx    = int'(a_addr) / 8;
        r.size = a_size;
        r.src  = a_src;
        r.den  = den;
        if (put) begin
            r.op   = 3'd0;
            r.data = 64'h0;
            if (!den) begin
                for (int b = 0; b < 8; b++) begin
                    if (a_mask[b]) mdl_mem[idx][8*b +: 8] = a_data[8*b +: 8];
                end
            end
        end else begin
            r.op   = 3'd1;
            r.data = den ? 64'h0 : mdl_mem[idx];
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        resp_t e;
        resp_t n;
        bit af;
        bit df;
        #1;
        chk_eq("a_ready", a_ready, q.size() < 2);
        chk_eq("d_valid", d_valid, q.size() > 0);
        if (q.size() > 0) begin
            e = q[0];
            chk_eq("d_opcode", d_op, e.op);
            chk_eq("d_size", d_size, e.size);
            chk_eq("d_source", d_src, e.src);
            chk_eq("d_data", d_data, e.data);
            chk_eq("d_denied", d_den, e.den);
        end
        af = a_valid && (q.size() < 2);
        df = d_rdy && (q.size() > 0);
        if (df) void'(q.pop_front());
        if (af) begin
            model_accept(n);
            q.push_back(n);
        end
        last_a_fire = af;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic [1:0] size, input logic [10:0] src,
                        input logic corrupt);
        a_op = op; a_addr = addr; a_mask = mask; a_data = data;
        a_size = size; a_src = src; a_corrupt = corrupt;
        a_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_a_fire) break;
        end
        chk_eq("send_accept", last_a_fire, 1);
        a_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        @(negedge clock);
        chk_eq("rst_a_ready", a_ready, 1);
        chk_eq("rst_d_valid", d_valid, 0);
        chk_eq("rst_d_bits", {d_op, d_size, d_src, d_den}, 0);
        chk_eq("rst_d_data", d_data, 0);
        reset = 1'b0;

        d_rdy = 1'b1;
        for (int w = 0; w < 16; w++) begin
            send(3'd0, 12'(w * 8), 8'hFF, {$urandom(), $urandom()}, 2'd3, 11'(w), 1'b0);
        end
        idle(2);

        send(3'd0, 12'h008, 8'hFF, 64'h1122334455667788, 2'd3, 11'd5, 1'b0);
        chk_eq("put_d_valid", d_valid, 1);
        chk_eq("put_d_opcode", d_op, 0);
        chk_eq("put_d_source", d_src, 5);
        chk_eq("put_d_data", d_data, 0);
        send(3'd4, 12'h008, 8'hFF, 64'h0, 2'd3, 11'd6, 1'b0);
        chk_eq("get_d_opcode", d_op, 1);
        chk_eq("get_d_data", d_data, 64'h1122334455667788);

        send(3'd1, 12'h008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 2'd3, 11'd7, 1'b0);
        send(3'd4, 12'h008, 8'hFF, 64'h0, 2'd3, 11'd8, 1'b0);
        chk_eq("partial_data", d_data, 64'h11223344_BBBBBBBB);
        idle(2);

        d_rdy = 1'b0;
        a_op = 3'd4; a_addr = 12'h010; a_size = 2'd3; a_corrupt = 1'b0; a_valid = 1'b1;
        a_src = 11'd10; cycle();
        chk_eq("stall_acc0", last_a_fire, 1);
        a_src = 11'd11; cycle();
        chk_eq("stall_acc1", last_a_fire, 1);
        a_src = 11'd12;
        chk_eq("stall_a_ready", a_ready, 0);
        cycle();
        chk_eq("stall_acc2", last_a_fire, 0);
        d_rdy = 1'b1;
        cycle();
        chk_eq("stall_fire_cycle", last_a_fire, 0);
        cycle();
        chk_eq("stall_after_fire", last_a_fire, 1);
        idle(3);

        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            a_op = 3'd4; a_addr = 12'($urandom_range(0, 15) * 8); a_src = 11'(100 + i);
            a_valid = 1'b1;
            cycle();
            cnt += int'(last_a_fire);
        end
        chk_eq("stream_accepts", cnt, 16);
        idle(3);

        d_rdy = 1'b0;
        send(3'd4, 12'h018, 8'hFF, 64'h0, 2'd3, 11'd20, 1'b0);
        send(3'd4, 12'h020, 8'hFF, 64'h0, 2'd3, 11'd21, 1'b0);
        reset = 1'b1;
        #1;
        chk_eq("midrst_d_valid", d_valid, 0);
        chk_eq("midrst_a_ready", a_ready, 1);
        q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        d_rdy = 1'b1;
        idle(3);

        send(3'd0, 12'h010, 8'hFF, 64'h0102030405060708, 2'd3, 11'd29, 1'b0);
        send(3'd0, 12'h010, 8'hFF, 64'hDEADBEEFCAFEF00D, 2'd3, 11'd30, 1'b1);
`ifdef TL_SCRATCHPAD_DENY_EN
        chk_eq("corrupt_denied", d_den, 1);
`else
        chk_eq("corrupt_denied", d_den, 0);
`endif
        send(3'd4, 12'h010, 8'hFF, 64'h0, 2'd3, 11'd31, 1'b0);
`ifdef TL_SCRATCHPAD_DENY_EN
        chk_eq("corrupt_readback", d_data, 64'h0102030405060708);
`else
        chk_eq("corrupt_readback", d_data, 64'hDEADBEEFCAFEF00D);
`endif
        send(3'd4, 12'h004, 8'hFF, 64'h0, 2'd3, 11'd32, 1'b0);
`ifdef TL_SCRATCHPAD_DENY_EN
        chk_eq("misalign_denied", d_den, 1);
        chk_eq("misalign_data", d_data, 0);
`else
        chk_eq("misalign_denied", d_den, 0);
`endif
        idle(2);

        for (int i = 0; i < 400; i++) begin
            int r;
            a_valid = ($urandom_range(0, 3) != 0);
            d_rdy   = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            if (r < 3)      a_op = 3'd0;
            else if (r < 5) a_op = 3'd1;
            else if (r < 7) a_op = 3'd4;
            else begin
                r = $urandom_range(0, 4);
                a_op = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : 3'(r + 3);
            end
            a_size = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) r = r & ~((1 << a_size) - 1);
            a_addr    = 12'($urandom_range(0, 15) * 8 + r);
            a_mask    = 8'($urandom());
            a_data    = {$urandom(), $urandom()};
            a_param   = 3'($urandom());
            a_src     = 11'($urandom());
            a_corrupt = ($urandom_range(0, 7) == 0);
            cycle();
        end
        d_rdy = 1'b1;
        idle(4);
        chk_eq("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_scratchpad_responder.md
# tl_scratchpad_responder

TileLink-UL responder (slave) terminating the A/D channel pair that a fragmenter-side coupler drives outward. Accepts Get, PutFullData and PutPartialData beats of at most 8 bytes on a 64-bit data bus. Services them from a local 64-bit-wide scratchpad RAM, and returns AccessAck or AccessAckData on the D channel through a 2-entry response queue. Sits at the leaf of a peripheral crossbar branch, directly behind a fragmenter output.

## Interface
- DEPTH, 512: scratchpad words, 64 bits each. Power of two, 2..512. Word index = address[11:3] modulo DEPTH.
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- auto_in_a_valid  in  1  request valid
- auto_in_a_ready  out  1  request accepted when valid&&ready
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- auto_in_a_bits_param  in  3  ignored
- auto_in_a_bits_size  in  2  log2 bytes (0..3)
- auto_in_a_bits_source  in  11  requester ID, echoed
- auto_in_a_bits_address  in  12  byte address
- auto_in_a_bits_mask  in  8  byte-lane write enables
- auto_in_a_bits_data  in  64  write data
- auto_in_a_bits_corrupt  in  1  write data poisoned
- auto_in_d_valid  out  1  response valid
- auto_in_d_ready  in  1  response consumed when valid&&ready
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- auto_in_d_bits_size  out  2  echo of a_size
- auto_in_d_bits_source  out  11  echo of a_source
- auto_in_d_bits_data  out  64  read word; 0 for AccessAck
- auto_in_d_bits_denied  out  1  request refused (see Configuration)

## Operation
- Stage A (accept cycle): on A fire, Put writes RAM byte lanes where mask=1. Get issues a synchronous read of the indexed word. Opcode, size, source and the denied flag are captured into a pipeline register.
- Stage R (next cycle): the pipeline register plus RAM read data are pushed into a 2-entry FIFO that drives D.
- Reservation counter `resv` (0..2) counts pipeline entries plus FIFO entries:
  - +1 on A fire, −1 on D fire; both in the same cycle leave it unchanged.
  - auto_in_a_ready = (resv < 2). No combinational path from d_ready to a_ready.
- D outputs come from the FIFO head. d_valid = FIFO non-empty. Head is held stable while d_valid && !d_ready.
- Get response: opcode 1, data = full 64-bit word, all lanes regardless of mask/size.
- Put response: opcode 0, data 64'h0.
- Responses return strictly in acceptance order.
- Ordering: a Put's write commits at the edge ending its accept cycle. Any Get accepted later, including the very next cycle, returns the updated bytes.
- Unrecognised opcodes (2,3,5,6,7) with the macro absent: treated as Get, opcode 1 returned.

## Timing
- Latency A fire → d_valid: exactly 1 cycle with an empty FIFO.
- Throughput: 1 request/cycle sustained while d_ready=1.
- With d_ready=0: at most 2 accepts, then a_ready=0 until a D fire. a_ready returns to 1 the cycle after that fire.
- Full FIFO (2 entries) and empty FIFO: pointers wrap modulo 2. Push and pop in the same cycle on a full FIFO are legal.
- Reset values: auto_in_a_ready=1, auto_in_d_valid=0, d_opcode/d_size/d_source/d_data/d_denied=0, resv=0, FIFO empty.
- Reset asserted mid-operation discards in-flight and queued responses immediately. RAM contents are not reset and are undefined after power-up.

## Configuration
- TL_SCRATCHPAD_DENY_EN defined: a request is denied if any of these hold:
  - opcode unsupported
  - address not aligned to 2^size
  - Put with a_bits_corrupt=1
  
  A denied request does not write RAM. It still gets a response in order, with d_denied=1. Denied Get/unsupported opcodes return opcode 1 with data 0; denied Puts return opcode 0.
- Undefined: d_denied tied to 0 and no checks made. Misaligned accesses ignore address[2:0]. A corrupt Put writes normally.

## Test plan
- Reset then PutFull addr 0x008, mask 8'hFF, data 64'h1122334455667788, source 5 → next cycle d_valid=1, opcode 0, source 5, data 0. Then Get 0x008 → opcode 1, data 64'h1122334455667788.
- PutPartial addr 0x008, mask 8'h0F, data 64'hAAAAAAAA_BBBBBBBB, immediately followed by Get 0x008 → data 64'h11223344_BBBBBBBB.
- Hold d_ready=0 and offer 3 back-to-back Gets → 2 accepted, a_ready=0 on the third. Release d_ready → responses arrive in source order, and the third is accepted the cycle after the first D fire.
- Streaming 16 Gets with d_ready=1 → 16 accepts in 16 consecutive cycles, responses on cycles 2..17 with matching sources.
- Reset pulse while 2 responses are queued → d_valid=0 and a_ready=1 in the reset cycle; no stale response after release.
- DENY_EN build: Get size 3 at 0x004 → d_denied=1, data 0. PutFull with corrupt=1 to 0x010, then Get 0x010 → prior contents unchanged. Non-DENY build: same corrupt Put writes, and d_denied stays 0.
